pipe_stage_skid: RTL

Parametrised inter-stage pipeline register for the five-stage CPU, the generalised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches. Carries IR, PC, a CTRL_W-bit control bundle and NCH data channels of DATA_W bits. A valid/ready handshake replaces the plain enable. Flush inserts a bubble. An optional two-entry skid buffer registers the upstream ready path without losing throughput.

---
 rtl/pipe_stage_skid_if.sv | 31 +++
 rtl/pipe_stage_skid.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake/payload bundle for pipe_stage_skid. master = upstream producer and
// downstream consumer side, slave = the pipeline stage itself.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 32,
  parameter int NCH    = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             ir_in;
  logic [31:0]             pc_in;
  logic [CTRL_W-1:0]       ctrl_in;
  logic [NCH*DATA_W-1:0]   data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             ir_out;
  logic [31:0]             pc_out;
  logic [CTRL_W-1:0]       ctrl_out;
  logic [NCH*DATA_W-1:0]   data_out;
  logic [1:0]              occ;

  modport master (
    output in_valid, ir_in, pc_in, ctrl_in, data_in, out_ready,
    input  in_ready, out_valid, ir_out, pc_out, ctrl_out, data_out, occ
  );

  modport slave (
    input  in_valid, ir_in, pc_in, ctrl_in, data_in, out_ready,
    output in_ready, out_valid, ir_out, pc_out, ctrl_out, data_out, occ
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Valid/ready inter-stage pipeline register with flush-to-bubble.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid buffer with registered in_ready.
module pipe_stage_skid #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 32,
  parameter int NCH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  pipe_stage_skid_if.slave    bus
);
  localparam int PW = 64 + CTRL_W + NCH*DATA_W;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] m_q, m_d;
  logic [PW-1:0] in_pay;
  logic          out_valid;
  logic          accept;
  logic          fire;

  assign in_pay    = {bus.ir_in, bus.pc_in, bus.ctrl_in, bus.data_in};
  assign {bus.ir_out, bus.pc_out, bus.ctrl_out, bus.data_out} = m_q;
  assign out_valid = (state_q != EMPTY);
  assign bus.out_valid = out_valid;
  // State encoding equals the entry count.
  assign bus.occ   = state_q;
  assign fire      = out_valid & bus.out_ready;
  assign accept    = bus.in_valid & bus.in_ready;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] TWO = 2'd2;

  logic [PW-1:0] s_q, s_d;
  logic          in_ready_q, in_ready_d;

  // Registered ready, only flush overrides it combinationally.
  assign bus.in_ready = in_ready_q & ~flush;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = in_pay;
          end
        end
        ONE: begin
          if (accept && fire) begin
            m_d     = in_pay;
          end else if (accept) begin
            state_d = TWO;
            s_d     = in_pay;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  assign bus.in_ready = (~out_valid | bus.out_ready) & ~flush;

  // A held beat can only be replaced when it fires, so accept always reloads M.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    if (flush) begin
      state_d = EMPTY;
      m_d     = '0;
    end else if (accept) begin
      state_d = ONE;
      m_d     = in_pay;
    end else if (fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end
`endif
endmodule
